// File: rtl/pixel_adc_pkg.sv
//============================================================================
// Module   : pixel_adc_pkg
// Purpose  : Shared types and constants for the single-slope ADC pixel row
//            controller: FSM state encoding, pipeline depths and a width
//            helper used for channel-index ports.
// Contents : state_t       - frame sequencing states
//            DRAIN_CYCLES  - ramp-off cycles that flush the sync pipeline
//            SYNC_STAGES   - comparator synchroniser depth
//            clog2_min1()  - ceil(log2(n)) but never below 1
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package pixel_adc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ERASE   = 3'd1,
    EXPOSE  = 3'd2,
    CONVERT = 3'd3,
    DRAIN   = 3'd4,
    READ    = 3'd5
  } state_t;

  // DRAIN must last at least SYNC_STAGES cycles so the final ramp samples
  // reach the latches before READ begins.
  localparam int DRAIN_CYCLES = 2;
  localparam int SYNC_STAGES  = 2;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_adc_latch.sv
//============================================================================
// Module   : pixel_adc_latch
// Purpose  : One ADC channel: comparator synchroniser, armed flag and the
//            W-bit code latch that tracks the pipelined ramp count until the
//            comparator first reports the ramp has crossed the pixel level.
// Ports    : clk, reset_n  - clock / async active-low reset
//            cmp_async     - raw comparator output (1 = ramp below pixel)
//            clear         - conversion start: zero latch and arm
//            window        - pipelined conversion window (aligned to count_d)
//            count_d       - ramp count delayed to match the synchroniser
//            code          - latched conversion result
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module pixel_adc_latch
  import pixel_adc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmp_async,
  input  logic         clear,
  input  logic         window,
  input  logic [W-1:0] count_d,
  output logic [W-1:0] code
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   armed;
  logic                   cmp_sync;

  assign cmp_sync = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], cmp_async};
    end
  end

  // The latch follows the count while the comparator still says "ramp
  // below pixel"; the first low sample disarms it, so any later glitch back
  // high cannot overwrite the captured code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code  <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      code  <= '0;
      armed <= 1'b1;
    end else if (window && armed) begin
      if (cmp_sync) begin
        code <= count_d;
      end else begin
        armed <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_array_ss_adc_ctrl.sv
//============================================================================
// Module   : pixel_array_ss_adc_ctrl
// Purpose  : Frame sequencer for a row of single-slope ADC pixels. Runs
//            ERASE -> EXPOSE -> CONVERT -> DRAIN -> READ, drives the shared
//            binary ramp count, latches one code per channel and streams the
//            codes out one channel per valid/ready beat.
// Ports    : clk, reset_n            - clock / async active-low reset
//            start, abort            - frame request / return to IDLE
//            expose_cycles           - exposure length, sampled on start
//            cmp[N_CH]               - asynchronous pixel comparators
//            erase, expose, ramp_en  - registered analog control strobes
//            busy                    - frame in progress
//            rd_data, rd_ch,
//            rd_valid, rd_ready      - readout stream
//            frame_done              - one-cycle pulse after last beat
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module pixel_array_ss_adc_ctrl
  import pixel_adc_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int W            = 8,
  parameter int ERASE_CYCLES = 5,
  parameter int EXP_W        = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [EXP_W-1:0]             expose_cycles,
  input  logic [N_CH-1:0]              cmp,
  output logic                         erase,
  output logic                         expose,
  output logic                         ramp_en,
  output logic                         busy,
  output logic [W-1:0]                 rd_data,
  output logic [clog2_min1(N_CH)-1:0]  rd_ch,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic                         frame_done
);

  localparam int CH_W  = clog2_min1(N_CH);
  localparam int ER_W  = clog2_min1(ERASE_CYCLES);
  localparam int TMR_W = (EXP_W > ER_W) ? EXP_W : ER_W;

  localparam logic [W-1:0]     MAX        = '1;
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(N_CH - 1);
  localparam logic [TMR_W-1:0] ERASE_LAST = TMR_W'(ERASE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_CYCLES - 1);

  state_t             state;
  state_t             state_nx;
  logic [EXP_W-1:0]   exp_len;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   exp_last;
  logic [W-1:0]       count;
  logic [W-1:0]       cnt_pipe [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] win_pipe;
  logic               conv_entry;
  logic               last_beat;
  logic [W-1:0]       codes [N_CH];

  assign exp_last   = TMR_W'(exp_len) - TMR_W'(1);
  assign conv_entry = (state_nx == CONVERT) && (state != CONVERT);
  assign last_beat  = (state == READ) && rd_ready && (rd_ch == CH_LAST);

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      // frame_done is still high in the first IDLE cycle; a start arriving
      // alongside it belongs to the frame that just ended and is dropped.
      IDLE:    if (start && !frame_done) state_nx = ERASE;
      ERASE:   if (timer == ERASE_LAST)
                 state_nx = (exp_len == '0) ? CONVERT : EXPOSE;
      EXPOSE:  if (timer == exp_last) state_nx = CONVERT;
      CONVERT: if (count == MAX) state_nx = DRAIN;
      DRAIN:   if (timer == DRAIN_LAST) state_nx = READ;
      READ:    if (last_beat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  //--------------------------------------------------------------------------
  // FSM: state-decoded outputs
  //--------------------------------------------------------------------------
  always_comb begin
    busy     = (state != IDLE);
    rd_valid = (state == READ);
    rd_data  = codes[rd_ch];
  end

  //--------------------------------------------------------------------------
  // Registered strobes, timers, ramp count and read pointer
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      erase      <= 1'b0;
      expose     <= 1'b0;
      ramp_en    <= 1'b0;
      frame_done <= 1'b0;
      exp_len    <= '0;
      timer      <= '0;
      count      <= '0;
      rd_ch      <= '0;
    end else begin
      // Strobes are decoded from the next state so each one is a clean
      // flop output that is high for exactly the cycles spent in its state.
      erase      <= (state_nx == ERASE);
      expose     <= (state_nx == EXPOSE);
      ramp_en    <= (state_nx == CONVERT);
      frame_done <= last_beat && !abort;

      if (state == IDLE && state_nx == ERASE) begin
        exp_len <= expose_cycles;
      end

      if (state == IDLE || state_nx != state) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if (conv_entry) begin
        count <= '0;
      end else if (state == CONVERT && count != MAX) begin
        count <= count + 1'b1;
      end

      if (state_nx == READ && state != READ) begin
        rd_ch <= '0;
      end else if (state == READ && rd_ready && !abort) begin
        rd_ch <= (rd_ch == CH_LAST) ? '0 : rd_ch + 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Count / window pipeline, matched in depth to the cmp synchronisers so
  // each synchronised comparator sample meets the ramp value it observed.
  // Abort empties the window so no latch moves after the frame is dropped.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_pipe <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) cnt_pipe[k] <= '0;
    end else begin
      win_pipe    <= abort ? '0 : {win_pipe[SYNC_STAGES-2:0], (state == CONVERT)};
      cnt_pipe[0] <= count;
      for (int k = 1; k < SYNC_STAGES; k++) cnt_pipe[k] <= cnt_pipe[k-1];
    end
  end

  //--------------------------------------------------------------------------
  // Per-channel latch bank
  //--------------------------------------------------------------------------
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pixel_adc_latch #(
      .W (W)
    ) u_latch (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmp_async (cmp[i]),
      .clear     (conv_entry),
      .window    (win_pipe[SYNC_STAGES-1]),
      .count_d   (cnt_pipe[SYNC_STAGES-1]),
      .code      (codes[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pixel_array_ss_adc_ctrl.sv
//============================================================================
// Module   : tb_pixel_array_ss_adc_ctrl
// Purpose  : Self-checking bench for pixel_array_ss_adc_ctrl. A comparator
//            model drives cmp from the observed ramp step; expected read
//            beats are queued when a frame is launched and compared against
//            every valid beat.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pixel_array_ss_adc_ctrl;

  localparam int N_CH         = 4;
  localparam int W            = 8;
  localparam int ERASE_CYCLES = 5;
  localparam int EXP_W        = 16;
  localparam int RAMP_STEPS   = 1 << W;
  localparam int NEVER        = 1 << 30;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              rd_ready = 1'b1;
  logic [EXP_W-1:0]  expose_cycles = '0;
  logic [N_CH-1:0]   cmp = '0;
  logic              erase, expose, ramp_en, busy, rd_valid, frame_done;
  logic [W-1:0]      rd_data;
  logic [1:0]        rd_ch;

  always #5 clk = ~clk;

  pixel_array_ss_adc_ctrl #(
    .N_CH         (N_CH),
    .W            (W),
    .ERASE_CYCLES (ERASE_CYCLES),
    .EXP_W        (EXP_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .expose_cycles (expose_cycles),
    .cmp           (cmp),
    .erase         (erase),
    .expose        (expose),
    .ramp_en       (ramp_en),
    .busy          (busy),
    .rd_data       (rd_data),
    .rd_ch         (rd_ch),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .frame_done    (frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Comparator model: cmp[i] is high while ramp step < fall_at[i], and again
  // from rise_at[i] onward (glitch).
  int fall_at [N_CH];
  int rise_at [N_CH];
  int step = 0;

  always @(negedge clk) begin
    if (ramp_en) begin
      for (int i = 0; i < N_CH; i++)
        cmp[i] = (step < fall_at[i]) || (step >= rise_at[i]);
      step++;
    end else begin
      step = 0;
    end
  end

  // Backpressure: hold rd_ready low for 3 cycles while beat 1 is offered.
  bit bp_en = 1'b0;
  int stall_n = 0;

  always @(posedge clk) begin
    #1;
    if (bp_en && rd_valid && rd_ch == 2'd1 && stall_n < 3) begin
      rd_ready = 1'b0;
      stall_n++;
    end else begin
      rd_ready = 1'b1;
    end
  end

  // Monitor + scoreboard
  typedef struct { int ch; int code; } beat_t;
  beat_t exp_q [$];

  int   n_erase, n_expose, n_ramp, n_fd, n_hs;
  int   excl_viol = 0;
  logic prev_erase = 1'b0, prev_expose = 1'b0, prev_ramp = 1'b0;
  int   ramp_src = 0;
  bit   prev_final = 1'b0;
  bit   final_now;

  always @(negedge clk) begin
    final_now = 1'b0;
    if (reset_n) begin
      n_erase  += int'(erase);
      n_expose += int'(expose);
      n_ramp   += int'(ramp_en);
      if (int'(erase) + int'(expose) + int'(ramp_en) > 1) excl_viol++;
      if (ramp_en && !prev_ramp) ramp_src = int'({prev_erase, prev_expose});
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected_valid", 1, 0);
        end else begin
          check("rd_ch", int'(rd_ch), exp_q[0].ch);
          check("rd_data", int'(rd_data), exp_q[0].code);
          if (rd_ready) begin
            final_now = (exp_q[0].ch == N_CH - 1);
            void'(exp_q.pop_front());
            n_hs++;
          end
        end
      end
      if (prev_final || frame_done)
        check("frame_done_pulse", int'(frame_done), int'(prev_final));
      if (frame_done) n_fd++;
    end
    prev_final  = final_now;
    prev_erase  = erase;
    prev_expose = expose;
    prev_ramp   = ramp_en;
  end

  function automatic int model_code(input int f);
    if (f <= 0) return 0;
    if (f >= RAMP_STEPS) return RAMP_STEPS - 1;
    return f - 1;
  endfunction

  task automatic set_cmp(input int f0, input int f1, input int f2, input int f3);
    fall_at[0] = f0; fall_at[1] = f1; fall_at[2] = f2; fall_at[3] = f3;
    for (int i = 0; i < N_CH; i++) rise_at[i] = NEVER;
  endtask

  task automatic clear_stats();
    n_erase = 0; n_expose = 0; n_ramp = 0; n_fd = 0; n_hs = 0; ramp_src = 0;
  endtask

  task automatic pulse_start(input int exp);
    @(posedge clk); #1;
    start = 1'b1;
    expose_cycles = EXP_W'(exp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int exp, input bit bp, input bit start_in_read);
    int c;
    clear_stats();
    for (int i = 0; i < N_CH; i++) exp_q.push_back('{i, model_code(fall_at[i])});
    bp_en = bp;
    stall_n = 0;
    pulse_start(exp);
    if (start_in_read) begin
      for (c = 0; c < 4000 && !rd_valid; c++) @(negedge clk);
      check("read_reached", int'(rd_valid), 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (c = 0; c < 4000 && n_fd == 0; c++) @(negedge clk);
    check("frame_done_seen", int'(n_fd != 0), 1);
    repeat (20) @(negedge clk);
    check("erase_cycles", n_erase, ERASE_CYCLES);
    check("expose_cycles", n_expose, exp);
    check("ramp_cycles", n_ramp, RAMP_STEPS);
    check("ramp_follows", ramp_src, (exp == 0) ? 2 : 1);
    check("handshakes", n_hs, N_CH);
    check("frame_done_count", n_fd, 1);
    check("idle_after_frame", int'(busy), 0);
    check("queue_empty", exp_q.size(), 0);
    bp_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    set_cmp(NEVER, NEVER, NEVER, NEVER);
    clear_stats();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          int'({busy, erase, expose, ramp_en, rd_valid, frame_done, rd_ch, rd_data}), 0);
    reset_n = 1'b1;

    // Nominal frame: trips at steps 1, 100, 255, never -> 0, 99, 254, 255
    set_cmp(1, 100, 255, NEVER);
    run_frame(10, 1'b0, 1'b0);

    // Zero exposure, backpressure on beat 1, cmp[2] glitch 50..60
    set_cmp(0, 20, 50, NEVER);
    rise_at[2] = 60;
    run_frame(0, 1'b1, 1'b0);

    // start during READ must not launch a second frame
    set_cmp(30, 5, 200, 128);
    run_frame(3, 1'b0, 1'b1);

    // Abort during EXPOSE, with an ignored start while busy
    clear_stats();
    set_cmp(10, 10, 10, 10);
    pulse_start(50);
    for (c = 0; c < 100 && !expose; c++) @(negedge clk);
    check("expose_reached", int'(expose), 1);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", int'({busy, erase, expose, ramp_en, rd_valid}), 0);
    repeat (30) @(negedge clk);
    check("abort_no_frame_done", n_fd, 0);
    check("abort_no_restart", int'(busy), 0);
    check("abort_erase_once", n_erase, ERASE_CYCLES);

    // Asynchronous reset in the middle of CONVERT
    set_cmp(NEVER, NEVER, NEVER, NEVER);
    pulse_start(2);
    for (c = 0; c < 100 && !ramp_en; c++) @(negedge clk);
    check("ramp_reached", int'(ramp_en), 1);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset", int'({busy, ramp_en, rd_valid}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // cmp held low throughout -> all codes 0
    set_cmp(0, 0, 0, 0);
    run_frame(2, 1'b0, 1'b0);

    check("exclusive_strobes", excl_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
